clk_div_monitor: RTL and testbench

//   Downstream checker for the clock divider: samples the divided clock in the i_ref_clk domain and

---
 rtl/clk_div_pkg.sv | 23 ++
 rtl/clk_div_monitor_phase_counter.sv | 40 ++++
 rtl/clk_div_monitor.sv | 123 ++++++++++++
 tb/tb_clk_div_monitor.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-divider monitor: FSM states and the
// expected high/low phase lengths for a programmed divide ratio.
package clk_div_pkg;

  localparam int DEF_RATIO_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    MEAS_HIGH,
    MEAS_LOW
  } mon_state_e;

  // Odd ratios put the extra reference cycle in the high phase.
  function automatic int unsigned exp_high(input int unsigned n);
    return (n >> 1) + {31'b0, n[0]};
  endfunction

  function automatic int unsigned exp_low(input int unsigned n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clk_div_monitor_phase_counter.sv
// Samples the divided clock in the reference domain, flags its edges and
// counts the length of the current phase, saturating at the timeout value.
module clk_phase_counter #(
  parameter int RATIO_WIDTH = clk_div_pkg::DEF_RATIO_WIDTH
) (
  input  logic                 i_ref_clk,
  input  logic                 i_rst_n,
  input  logic                 div_clk,
  output logic                 rise,
  output logic                 fall,
  output logic [RATIO_WIDTH:0] phase_cnt,
  output logic                 timeout
);

  localparam logic [RATIO_WIDTH:0] CNT_MAX = {1'b1, {RATIO_WIDTH{1'b0}}};
  localparam logic [RATIO_WIDTH:0] CNT_ONE = (RATIO_WIDTH+1)'(1);

  logic                 sample_reg;
  logic [RATIO_WIDTH:0] cnt_reg;

  assign rise      = div_clk & ~sample_reg;
  assign fall      = ~div_clk & sample_reg;
  assign phase_cnt = cnt_reg;
  assign timeout   = (cnt_reg == CNT_MAX);

  // The edge cycle itself is the first sample of the new phase.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sample_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sample_reg <= div_clk;
      if (rise || fall)
        cnt_reg <= CNT_ONE;
      else if (cnt_reg != CNT_MAX)
        cnt_reg <= cnt_reg + CNT_ONE;
    end
  end

endmodule

// File: rtl/clk_div_monitor.sv
// Checks each divided-clock period against the shape expected for the
// programmed ratio; tracks lock, sticky mismatch/stuck flags and an error count.
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int RATIO_WIDTH   = clk_div_pkg::DEF_RATIO_WIDTH,
  parameter int LOCK_PERIODS  = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     i_ref_clk,
  input  logic                     i_rst_n,
  input  logic                     i_mon_en,
  input  logic                     i_clk_en,
  input  logic [RATIO_WIDTH-1:0]   i_div_ratio,
  input  logic                     i_div_clk,
  input  logic                     i_err_clr,
  output logic                     o_locked,
  output logic                     o_err,
  output logic                     o_stuck,
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt,
  output logic [RATIO_WIDTH:0]     o_high_time,
  output logic [RATIO_WIDTH:0]     o_low_time,
  output logic                     o_meas_valid
);

  localparam int TW = RATIO_WIDTH + 1;
  localparam int GW = $clog2(LOCK_PERIODS + 1);
  localparam logic [GW-1:0] LOCK_TGT = GW'(LOCK_PERIODS);

  mon_state_e             state_reg;
  logic [RATIO_WIDTH-1:0] ratio_reg;
  logic [TW-1:0]          high_len_reg;
  logic [GW-1:0]          good_cnt_reg;

  logic                     rise, fall, timeout;
  logic [TW-1:0]            phase_cnt;
  logic                     active, abort, match;
  logic [TW-1:0]            exp_high_len, exp_low_len;
  logic [GW-1:0]            good_cnt_next;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_next;

  clk_phase_counter #(.RATIO_WIDTH(RATIO_WIDTH)) u_phase_counter (
    .i_ref_clk (i_ref_clk),
    .i_rst_n   (i_rst_n),
    .div_clk   (i_div_clk),
    .rise      (rise),
    .fall      (fall),
    .phase_cnt (phase_cnt),
    .timeout   (timeout)
  );

  // Ratios 0/1 mean the divider is bypassed, so there is no shape to check.
  assign active       = i_mon_en & i_clk_en & (i_div_ratio >= RATIO_WIDTH'(2));
  assign abort        = ~active | (i_div_ratio != ratio_reg);
  assign exp_high_len = TW'(exp_high(32'(i_div_ratio)));
  assign exp_low_len  = TW'(exp_low(32'(i_div_ratio)));
  assign match        = (high_len_reg == exp_high_len) && (phase_cnt == exp_low_len);

  assign good_cnt_next = (good_cnt_reg == LOCK_TGT) ? good_cnt_reg : good_cnt_reg + GW'(1);
  // A clear in the same cycle as a new mismatch restarts the count at one.
  assign err_cnt_next  = i_err_clr   ? ERR_CNT_WIDTH'(1) :
                         (&o_err_cnt) ? o_err_cnt : o_err_cnt + ERR_CNT_WIDTH'(1);

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      ratio_reg    <= '0;
      high_len_reg <= '0;
      good_cnt_reg <= '0;
      o_locked     <= 1'b0;
      o_err        <= 1'b0;
      o_stuck      <= 1'b0;
      o_err_cnt    <= '0;
      o_high_time  <= '0;
      o_low_time   <= '0;
      o_meas_valid <= 1'b0;
    end else begin
      ratio_reg    <= i_div_ratio;
      o_meas_valid <= 1'b0;
      if (i_err_clr) begin
        o_err     <= 1'b0;
        o_stuck   <= 1'b0;
        o_err_cnt <= '0;
      end
      if (abort) begin
        state_reg    <= IDLE;
        good_cnt_reg <= '0;
        o_locked     <= 1'b0;
      end else begin
        unique case (state_reg)
          IDLE: state_reg <= SYNC;
          SYNC: if (rise) state_reg <= MEAS_HIGH;
          MEAS_HIGH, MEAS_LOW: begin
            if (timeout) begin
              o_stuck      <= 1'b1;
              o_locked     <= 1'b0;
              good_cnt_reg <= '0;
              state_reg    <= SYNC;
            end else if (state_reg == MEAS_HIGH && fall) begin
              high_len_reg <= phase_cnt;
              state_reg    <= MEAS_LOW;
            end else if (state_reg == MEAS_LOW && rise) begin
              o_meas_valid <= 1'b1;
              o_high_time  <= high_len_reg;
              o_low_time   <= phase_cnt;
              state_reg    <= MEAS_HIGH;
              if (match) begin
                good_cnt_reg <= good_cnt_next;
                o_locked     <= (good_cnt_next == LOCK_TGT);
              end else begin
                o_err        <= 1'b1;
                o_err_cnt    <= err_cnt_next;
                good_cnt_reg <= '0;
                o_locked     <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: a behavioural divider drives i_div_clk,
// with hooks to stretch one high phase or hold the clock high.
module tb_clk_div_monitor;

  localparam int RW = 8;

  logic          i_ref_clk = 1'b0;
  logic          i_rst_n;
  logic          i_mon_en;
  logic          i_clk_en;
  logic [RW-1:0] i_div_ratio;
  logic          i_div_clk;
  logic          i_err_clr;
  logic          o_locked;
  logic          o_err;
  logic          o_stuck;
  logic [7:0]    o_err_cnt;
  logic [RW:0]   o_high_time;
  logic [RW:0]   o_low_time;
  logic          o_meas_valid;

  clk_div_monitor #(.RATIO_WIDTH(RW), .LOCK_PERIODS(4), .ERR_CNT_WIDTH(8)) dut (
    .i_ref_clk    (i_ref_clk),
    .i_rst_n      (i_rst_n),
    .i_mon_en     (i_mon_en),
    .i_clk_en     (i_clk_en),
    .i_div_ratio  (i_div_ratio),
    .i_div_clk    (i_div_clk),
    .i_err_clr    (i_err_clr),
    .o_locked     (o_locked),
    .o_err        (o_err),
    .o_stuck      (o_stuck),
    .o_err_cnt    (o_err_cnt),
    .o_high_time  (o_high_time),
    .o_low_time   (o_low_time),
    .o_meas_valid (o_meas_valid)
  );

  always #5 i_ref_clk = ~i_ref_clk;

  int errors = 0;
  int checks = 0;
  int div_cnt = 0;
  int n_ratio = 0;
  bit stall_req = 0;
  bit hold_high = 0;
  int valid_seen = 0;
  int last_high = 0;
  int last_low = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Divider model: counter 0..N-1, high for the first ceil(N/2) counts.
  task automatic drive_div();
    if (hold_high)
      i_div_clk = 1'b1;
    else
      i_div_clk = (n_ratio >= 2) ? (div_cnt < (n_ratio + 1) / 2) : 1'b1;
  endtask

  task automatic set_ratio(input int n);
    n_ratio     = n;
    i_div_ratio = RW'(n);
    div_cnt     = 0;
    drive_div();
  endtask

  task automatic tick();
    @(posedge i_ref_clk);
    #1;
    if (o_meas_valid) begin
      valid_seen++;
      last_high = int'(o_high_time);
      last_low  = int'(o_low_time);
      $display("meas %0d: N=%0d high=%0d low=%0d locked=%0d err=%0d err_cnt=%0d",
               valid_seen, n_ratio, last_high, last_low, o_locked, o_err, o_err_cnt);
    end
    if (stall_req && i_div_clk && !hold_high)
      stall_req = 0;
    else if (n_ratio >= 2)
      div_cnt = (div_cnt + 1 >= n_ratio) ? 0 : div_cnt + 1;
    drive_div();
  endtask

  // Wait for k measurements; eh<0 skips the per-measurement shape check.
  task automatic run_meas(input int k, input int eh, input int el, input string tag);
    int start;
    int budget;
    start  = valid_seen;
    budget = 0;
    while (valid_seen - start < k && budget < 2000) begin
      tick();
      budget++;
      if (o_meas_valid && eh >= 0) begin
        check({tag, "_high"}, last_high, eh);
        check({tag, "_low"}, last_low, el);
      end
    end
    if (valid_seen - start < k)
      check({tag, "_meas_timeout"}, valid_seen - start, k);
  endtask

  task automatic count_valid(input int cycles, output int seen);
    int start;
    start = valid_seen;
    repeat (cycles) tick();
    seen = valid_seen - start;
  endtask

  initial begin
    int seen;
    i_rst_n   = 1'b0;
    i_mon_en  = 1'b0;
    i_clk_en  = 1'b0;
    i_err_clr = 1'b0;
    set_ratio(0);
    repeat (3) @(posedge i_ref_clk);
    #1;
    check("rst_locked", o_locked, 0);
    check("rst_err", o_err, 0);
    check("rst_stuck", o_stuck, 0);
    check("rst_err_cnt", o_err_cnt, 0);
    check("rst_high", o_high_time, 0);
    check("rst_valid", o_meas_valid, 0);

    // N=4: lock on the fourth good period
    set_ratio(4);
    i_mon_en = 1'b1;
    i_clk_en = 1'b1;
    i_rst_n  = 1'b1;
    run_meas(3, 2, 2, "n4");
    check("n4_locked_after3", o_locked, 0);
    run_meas(1, 2, 2, "n4");
    check("n4_locked_after4", o_locked, 1);
    check("n4_err", o_err, 0);

    // Odd ratios
    set_ratio(5);
    run_meas(5, 3, 2, "n5");
    check("n5_locked", o_locked, 1);
    set_ratio(7);
    run_meas(5, 4, 3, "n7");
    check("n7_locked", o_locked, 1);
    check("n7_err", o_err, 0);

    // N=6 with one high phase stretched by a cycle
    set_ratio(6);
    run_meas(5, 3, 3, "n6");
    check("n6_locked", o_locked, 1);
    stall_req = 1;
    run_meas(1, -1, -1, "n6_bad");
    check("n6_bad_high", last_high, 4);
    check("n6_bad_low", last_low, 3);
    check("n6_bad_err", o_err, 1);
    check("n6_bad_err_cnt", o_err_cnt, 1);
    check("n6_bad_locked", o_locked, 0);
    run_meas(3, 3, 3, "n6_relock");
    check("n6_relock_not_yet", o_locked, 0);
    run_meas(1, 3, 3, "n6_relock");
    check("n6_relocked", o_locked, 1);

    // Clock stuck high: timeout at phase count 256
    hold_high = 1;
    drive_div();
    count_valid(240, seen);
    check("stuck_early", o_stuck, 0);
    count_valid(60, seen);
    check("stuck_set", o_stuck, 1);
    check("stuck_locked", o_locked, 0);
    check("stuck_no_valid", seen, 0);
    check("stuck_err_cnt", o_err_cnt, 1);
    hold_high = 0;
    drive_div();
    run_meas(5, 3, 3, "unstuck");
    check("unstuck_locked", o_locked, 1);

    // Ratio change 4 -> 3 mid-period
    set_ratio(4);
    run_meas(5, 2, 2, "n4b");
    check("n4b_locked", o_locked, 1);
    tick();
    set_ratio(3);
    tick();
    check("chg_unlocked", o_locked, 0);
    check("chg_err_cnt", o_err_cnt, 1);
    run_meas(5, 2, 1, "n3");
    check("n3_locked", o_locked, 1);
    check("n3_err_cnt", o_err_cnt, 1);

    // Bypass ratio and disabled divider are not checked
    set_ratio(1);
    count_valid(50, seen);
    check("n1_no_valid", seen, 0);
    check("n1_locked", o_locked, 0);
    set_ratio(4);
    i_clk_en = 1'b0;
    count_valid(50, seen);
    check("clk_en0_no_valid", seen, 0);

    // Clear sticky status
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    check("clr_err", o_err, 0);
    check("clr_stuck", o_stuck, 0);
    check("clr_err_cnt", o_err_cnt, 0);

    // Asynchronous reset while measuring the low phase
    i_clk_en = 1'b1;
    run_meas(2, 2, 2, "pre_rst");
    check("pre_rst_err", o_err, 0);
    tick();
    tick();
    i_rst_n = 1'b0;
    #1;
    check("arst_high", o_high_time, 0);
    check("arst_low", o_low_time, 0);
    check("arst_valid", o_meas_valid, 0);
    check("arst_locked", o_locked, 0);
    check("arst_err_cnt", o_err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
